dmem_sweep: RTL and testbench
=============================

Name: dmem_sweep

Overview:
- Parametrised single-clock data memory; next generation of the processor's 4x16 data memory.
- Adds a registered primary read port, a registered debug/display read port and a hardware clear sequencer that sweeps every word to INIT_VAL after reset or on request.
- Adds read-during-write forwarding and out-of-range address protection.
- Sits in the MEM stage of the pipeline; the debug port feeds the board display logic.

Parameters:
- DATA_W, 4, word width in bits.
- DEPTH, 16, number of words; need not be a power of two, must be >= 2.
- ADDR_W, 4, address width; must satisfy 2**ADDR_W >= DEPTH.
- INIT_VAL, 0, value written to every word by the clear sweep (DATA_W bits).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous request to re-run the clear sweep; sampled only in RUN.
- WE  in  1  write enable, primary port.
- addr  in  ADDR_W  primary read/write address.
- DI  in  DATA_W  write data.
- DO  out  DATA_W  registered primary read data.
- doutadr  in  ADDR_W  debug read address.
- dout  out  DATA_W  registered debug read data.
- ready  out  1  high when the memory accepts accesses (state RUN).
- wr_drop  out  1  one-cycle pulse when a write is discarded.
- par_err  out  1  parity error flag (see Optional Feature).

Behaviour:
- Reset: while rst=1, state=CLEAR, ptr=0, DO=0, dout=0, ready=0, wr_drop=0, par_err=0. Array contents are not reset directly.
- CLEAR state:
  - Each cycle writes INIT_VAL to mem[ptr], then increments ptr.
  - On the cycle that writes ptr==DEPTH-1: ptr returns to 0 and the next state is RUN.
  - The sweep takes exactly DEPTH cycles after rst deasserts; ready rises on cycle DEPTH+1.
  - WE=1 during CLEAR: write discarded, wr_drop=1 next cycle.
  - DO and dout hold 0 throughout CLEAR; clr is ignored.
- RUN state:
  - Write: if WE=1 and addr<DEPTH, mem[addr]<=DI.
  - Out-of-range write: if WE=1 and addr>=DEPTH, nothing is written and wr_drop pulses.
  - Primary read: DO<=mem[addr] one cycle after addr is presented; latency 1.
  - Debug read: dout<=mem[doutadr]; latency 1.
  - Forwarding: if WE=1 and the read address equals addr (in range), that port's register loads DI, not the old contents (write-first). This applies independently to DO and dout.
  - Out-of-range read: addr>=DEPTH gives DO<=0; doutadr>=DEPTH gives dout<=0.
  - clr=1: next state CLEAR, ptr=0, ready drops next cycle. A WE in the same cycle as clr is performed; the sweep then overwrites it.
- Reset mid-sweep: the sweep restarts from ptr=0.
- Only the two states CLEAR and RUN exist. ptr is ADDR_W bits and never exceeds DEPTH-1.

Optional Feature:
- Macro: DMEM_PARITY_EN.
- With the macro defined:
  - Each word stores DATA_W+1 bits: data plus even parity (XOR of data).
  - The sweep and all writes store the correct parity.
  - A primary read in RUN sets par_err, registered alongside DO, for one cycle when the stored parity mismatches.
  - Forwarded reads never flag.
  - Fault-injection hooks are bench-only.
- Without the macro: the array is DATA_W wide and par_err is tied to 0.

Decomposition:
- Shared package dmem_pkg holds:
  - state enum (CLEAR, RUN);
  - default DATA_W/DEPTH/ADDR_W constants;
  - a parity function.
- One sub-module is natural: dmem_sweep_ctrl, containing the CLEAR/RUN FSM, ptr counter, ready and wr_drop generation.
- The array, read registers and forwarding stay in the top module.

Test Plan:
- Reset release, defaults (DATA_W=4, DEPTH=16, INIT_VAL=4'h0): ready rises exactly 17 cycles after rst falls; reading all 16 addresses gives DO=4'h0.
- RUN: write 4'hA to addr 3, then read addr 3 next cycle -> DO=4'hA one cycle later; doutadr=3 -> dout=4'hA.
- Same cycle: WE=1, addr=5, DI=4'h7, doutadr=5 (old value 4'h2) -> DO=4'h7 and dout=4'h7 next cycle.
- DEPTH=12: WE=1, addr=13 -> wr_drop pulses for one cycle, no word changes, DO=0.
- After writing 4'hF to addr 0, pulse clr -> ready low for 16 cycles; afterwards addr 0 reads 4'h0.
- rst asserted at sweep cycle 6 -> sweep restarts; ready rises 17 cycles after rst falls; a WE during the sweep produces wr_drop=1 and the write is lost.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared state type, default geometry and parity helper for dmem_sweep
package dmem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_ADDR_W = 4;

  // Callers zero-extend narrower words; the extra zeros do not change the result.
  function automatic logic even_parity(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/dmem_sweep_ctrl.sv
// rtl/dmem_sweep_ctrl.sv - CLEAR/RUN sequencer: sweep pointer, ready and write-drop flags
module dmem_sweep_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic              addr_ok_i,
  output state_e            state_o,
  output logic [ADDR_W-1:0] ptr_o,
  output logic              ready_o,
  output logic              wr_drop_o
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              ready_q, ready_d;
  logic              drop_q, drop_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      ready_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ready_q <= ready_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    // ready trails the state by one cycle so it rises DEPTH+1 cycles after reset
    ready_d = (state_q == RUN);
    drop_d  = 1'b0;
    case (state_q)
      CLEAR: begin
        drop_d = we_i;
        if (ptr_q == LAST) begin
          ptr_d   = '0;
          state_d = RUN;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      RUN: begin
        drop_d = we_i && !addr_ok_i;
        if (clr_i) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  assign state_o   = state_q;
  assign ptr_o     = ptr_q;
  assign ready_o   = ready_q;
  assign wr_drop_o = drop_q;

endmodule

// File: rtl/dmem_sweep.sv
// rtl/dmem_sweep.sv - data memory with clear sweep, registered primary/debug reads, write-first forwarding
// Optional stored parity and par_err flag when DMEM_PARITY_EN is defined.
module dmem_sweep
  import dmem_pkg::*;
#(
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                DEPTH    = DEF_DEPTH,
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              WE,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] DI,
  output logic [DATA_W-1:0] DO,
  input  logic [ADDR_W-1:0] doutadr,
  output logic [DATA_W-1:0] dout,
  output logic              ready,
  output logic              wr_drop,
  output logic              par_err
);

`ifdef DMEM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  function automatic logic [WORD_W-1:0] enc(input logic [DATA_W-1:0] v);
`ifdef DMEM_PARITY_EN
    return {even_parity(64'(v)), v};
`else
    return v;
`endif
  endfunction

  logic [WORD_W-1:0] mem [DEPTH];

  state_e            state;
  logic [ADDR_W-1:0] ptr;
  logic              addr_ok, dadr_ok, run, wr_en;
  logic [WORD_W-1:0] rd_word, dbg_word;
  logic [DATA_W-1:0] do_q, do_d, dout_q, dout_d;

  assign addr_ok  = ({1'b0, addr} < DEPTH_W);
  assign dadr_ok  = ({1'b0, doutadr} < DEPTH_W);
  assign run      = (state == RUN);
  assign wr_en    = run && WE && addr_ok;
  assign rd_word  = mem[addr];
  assign dbg_word = mem[doutadr];

  dmem_sweep_ctrl #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (clr),
    .we_i     (WE),
    .addr_ok_i(addr_ok),
    .state_o  (state),
    .ptr_o    (ptr),
    .ready_o  (ready),
    .wr_drop_o(wr_drop)
  );

  always_ff @(posedge clk) begin
    if (!run) begin
      mem[ptr] <= enc(INIT_VAL);
    end else if (wr_en) begin
      mem[addr] <= enc(DI);
    end
  end

  // Write-first: a same-cycle write to the read address is returned instead of the old word.
  always_comb begin
    do_d   = '0;
    dout_d = '0;
    if (run) begin
      if (addr_ok) do_d = WE ? DI : rd_word[DATA_W-1:0];
      if (dadr_ok) dout_d = (wr_en && doutadr == addr) ? DI : dbg_word[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      do_q   <= '0;
      dout_q <= '0;
    end else begin
      do_q   <= do_d;
      dout_q <= dout_d;
    end
  end

  assign DO   = do_q;
  assign dout = dout_q;

`ifdef DMEM_PARITY_EN
  logic par_q, par_d;

  assign par_d = run && addr_ok && !WE &&
                 (rd_word[DATA_W] != even_parity(64'(rd_word[DATA_W-1:0])));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) par_q <= 1'b0;
    else     par_q <= par_d;
  end

  assign par_err = par_q;
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_sweep.sv
// tb/tb_dmem_sweep.sv - self-checking bench for dmem_sweep (DEPTH=16 and DEPTH=12 instances side by side)
module tb_dmem_sweep;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic       we  = 1'b0;
  logic [3:0] addr = 4'h0;
  logic [3:0] di   = 4'h0;
  logic [3:0] dadr = 4'h0;

  logic [3:0] o_do16, o_dout16, o_do12, o_dout12;
  logic       o_rdy16, o_drop16, o_par16, o_rdy12, o_drop12, o_par12;

  logic [3:0] a_do [2];
  logic [3:0] a_dout [2];
  logic       a_rdy [2];
  logic       a_drop [2];
  logic       a_par [2];

  assign a_do[0] = o_do16;     assign a_do[1] = o_do12;
  assign a_dout[0] = o_dout16; assign a_dout[1] = o_dout12;
  assign a_rdy[0] = o_rdy16;   assign a_rdy[1] = o_rdy12;
  assign a_drop[0] = o_drop16; assign a_drop[1] = o_drop12;
  assign a_par[0] = o_par16;   assign a_par[1] = o_par12;

  always #5 clk = ~clk;

  dmem_sweep u_dut16 (
    .clk(clk), .rst(rst), .clr(clr), .WE(we), .addr(addr), .DI(di), .DO(o_do16),
    .doutadr(dadr), .dout(o_dout16), .ready(o_rdy16), .wr_drop(o_drop16), .par_err(o_par16)
  );

  dmem_sweep #(.DATA_W(4), .DEPTH(12), .ADDR_W(4), .INIT_VAL(4'h0)) u_dut12 (
    .clk(clk), .rst(rst), .clr(clr), .WE(we), .addr(addr), .DI(di), .DO(o_do12),
    .doutadr(dadr), .dout(o_dout12), .ready(o_rdy12), .wr_drop(o_drop12), .par_err(o_par12)
  );

  // Reference model: per instance, a word array plus "sweep in progress" and how many words swept.
  logic [3:0] mm [2][16];
  bit         clearing [2];
  int         swept [2];
  logic [3:0] e_do [2];
  logic [3:0] e_dout [2];
  bit         e_rdy [2];
  bit         e_drop [2];

  int total = 0;
  int bad   = 0;

  function automatic int dep(input int k);
    return (k == 0) ? 16 : 12;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      clearing[k] = 1'b1;
      swept[k]    = 0;
      e_do[k]     = 4'h0;
      e_dout[k]   = 4'h0;
      e_rdy[k]    = 1'b0;
      e_drop[k]   = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int  d = dep(k);
      bit  was_run = !clearing[k];
      bit  a_in = int'(addr) < d;
      bit  d_in = int'(dadr) < d;
      if (clearing[k]) begin
        e_do[k]   = 4'h0;
        e_dout[k] = 4'h0;
        e_drop[k] = we;
        mm[k][swept[k]] = 4'h0;
        swept[k]++;
        if (swept[k] == d) clearing[k] = 1'b0;
      end else begin
        e_drop[k] = we && !a_in;
        e_do[k]   = !a_in ? 4'h0 : (we ? di : mm[k][addr]);
        e_dout[k] = !d_in ? 4'h0 : ((we && a_in && dadr == addr) ? di : mm[k][dadr]);
        if (we && a_in) mm[k][addr] = di;
        if (clr) begin
          clearing[k] = 1'b1;
          swept[k]    = 0;
        end
      end
      e_rdy[k] = was_run;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
  endtask

  task automatic test_reset();
    int first [2];
    rst = 1'b1;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      total++; if (a_do[k] !== 4'h0) begin bad++; $display("FAIL reset_do[%0d] got=%h want=0", k, a_do[k]); end
      total++; if (a_dout[k] !== 4'h0) begin bad++; $display("FAIL reset_dout[%0d] got=%h want=0", k, a_dout[k]); end
      total++; if (a_rdy[k] !== 1'b0) begin bad++; $display("FAIL reset_ready[%0d] got=%b want=0", k, a_rdy[k]); end
      total++; if (a_drop[k] !== 1'b0) begin bad++; $display("FAIL reset_drop[%0d] got=%b want=0", k, a_drop[k]); end
      total++; if (a_par[k] !== 1'b0) begin bad++; $display("FAIL reset_par[%0d] got=%b want=0", k, a_par[k]); end
    end
    step(); step();
    rst = 1'b0;
    first[0] = 0; first[1] = 0;
    for (int n = 1; n <= 40; n++) begin
      step();
      for (int k = 0; k < 2; k++) if (first[k] == 0 && a_rdy[k] === 1'b1) first[k] = n;
    end
    total++; if (first[0] != 17) begin bad++; $display("FAIL ready_rise16 got=%0d want=17", first[0]); end
    total++; if (first[1] != 13) begin bad++; $display("FAIL ready_rise12 got=%0d want=13", first[1]); end
    for (int i = 0; i < 16; i++) begin
      addr = 4'(i);
      step();
      for (int k = 0; k < 2; k++) begin
        total++; if (a_do[k] !== 4'h0) begin bad++; $display("FAIL init_read[%0d] addr=%0d got=%h want=0", k, i, a_do[k]); end
      end
    end
  endtask

  task automatic test_write_read();
    we = 1'b1; addr = 4'd3; di = 4'hA;
    step();
    we = 1'b0; dadr = 4'd3;
    step();
    for (int k = 0; k < 2; k++) begin
      total++; if (a_do[k] !== 4'hA) begin bad++; $display("FAIL wr_rd_do[%0d] got=%h want=a", k, a_do[k]); end
      total++; if (a_dout[k] !== 4'hA) begin bad++; $display("FAIL wr_rd_dout[%0d] got=%h want=a", k, a_dout[k]); end
    end
  endtask

  task automatic test_forward();
    we = 1'b1; addr = 4'd5; di = 4'h2;
    step();
    we = 1'b0; dadr = 4'd5;
    step();
    for (int k = 0; k < 2; k++) begin
      total++; if (a_dout[k] !== 4'h2) begin bad++; $display("FAIL fwd_old[%0d] got=%h want=2", k, a_dout[k]); end
    end
    we = 1'b1; di = 4'h7;
    step();
    we = 1'b0;
    for (int k = 0; k < 2; k++) begin
      total++; if (a_do[k] !== 4'h7) begin bad++; $display("FAIL fwd_do[%0d] got=%h want=7", k, a_do[k]); end
      total++; if (a_dout[k] !== 4'h7) begin bad++; $display("FAIL fwd_dout[%0d] got=%h want=7", k, a_dout[k]); end
    end
  endtask

  task automatic test_out_of_range();
    we = 1'b1; addr = 4'd13; di = 4'h9; dadr = 4'd13;
    step();
    we = 1'b0;
    total++; if (a_drop[1] !== 1'b1) begin bad++; $display("FAIL oor_drop12 got=%b want=1", a_drop[1]); end
    total++; if (a_do[1] !== 4'h0) begin bad++; $display("FAIL oor_do12 got=%h want=0", a_do[1]); end
    total++; if (a_dout[1] !== 4'h0) begin bad++; $display("FAIL oor_dout12 got=%h want=0", a_dout[1]); end
    total++; if (a_drop[0] !== 1'b0) begin bad++; $display("FAIL inr_drop16 got=%b want=0", a_drop[0]); end
    total++; if (a_do[0] !== 4'h9) begin bad++; $display("FAIL inr_do16 got=%h want=9", a_do[0]); end
    step();
    total++; if (a_drop[1] !== 1'b0) begin bad++; $display("FAIL oor_pulse12 got=%b want=0", a_drop[1]); end
    for (int i = 0; i < 12; i++) begin
      addr = 4'(i);
      step();
      total++; if (a_do[1] !== e_do[1]) begin bad++; $display("FAIL oor_nochange addr=%0d got=%h want=%h", i, a_do[1], e_do[1]); end
    end
  endtask

  task automatic test_clr();
    int low [2];
    we = 1'b1; addr = 4'd0; di = 4'hF;
    step();
    we = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
    for (int k = 0; k < 2; k++) begin
      total++; if (a_rdy[k] !== 1'b1) begin bad++; $display("FAIL clr_ready_hold[%0d] got=%b want=1", k, a_rdy[k]); end
    end
    low[0] = 0; low[1] = 0;
    for (int n = 0; n < 20; n++) begin
      step();
      for (int k = 0; k < 2; k++) if (a_rdy[k] !== 1'b1) low[k]++;
    end
    total++; if (low[0] != 16) begin bad++; $display("FAIL clr_low16 got=%0d want=16", low[0]); end
    total++; if (low[1] != 12) begin bad++; $display("FAIL clr_low12 got=%0d want=12", low[1]); end
    addr = 4'd0;
    step();
    for (int k = 0; k < 2; k++) begin
      total++; if (a_do[k] !== 4'h0) begin bad++; $display("FAIL clr_addr0[%0d] got=%h want=0", k, a_do[k]); end
    end
  endtask

  task automatic test_reset_mid();
    int first [2];
    rst = 1'b1; model_reset();
    step();
    rst = 1'b0;
    for (int n = 0; n < 6; n++) step();
    rst = 1'b1; model_reset();
    step();
    rst = 1'b0;
    first[0] = 0; first[1] = 0;
    for (int n = 1; n <= 40; n++) begin
      we = (n == 4); addr = 4'd2; di = 4'h5;
      step();
      if (n == 4) begin
        for (int k = 0; k < 2; k++) begin
          total++; if (a_drop[k] !== 1'b1) begin bad++; $display("FAIL sweep_drop[%0d] got=%b want=1", k, a_drop[k]); end
        end
      end
      for (int k = 0; k < 2; k++) if (first[k] == 0 && a_rdy[k] === 1'b1) first[k] = n;
    end
    we = 1'b0;
    total++; if (first[0] != 17) begin bad++; $display("FAIL mid_ready16 got=%0d want=17", first[0]); end
    total++; if (first[1] != 13) begin bad++; $display("FAIL mid_ready12 got=%0d want=13", first[1]); end
    step();
    for (int k = 0; k < 2; k++) begin
      total++; if (a_do[k] !== 4'h0) begin bad++; $display("FAIL sweep_lost[%0d] got=%h want=0", k, a_do[k]); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      we   = 1'($urandom_range(0, 1));
      addr = 4'($urandom_range(0, 15));
      di   = 4'($urandom_range(0, 15));
      dadr = 4'($urandom_range(0, 15));
      clr  = ($urandom_range(0, 49) == 0);
      step();
      for (int k = 0; k < 2; k++) begin
        total++; if (a_do[k] !== e_do[k]) begin bad++; $display("FAIL rnd_do[%0d] cyc=%0d got=%h want=%h", k, n, a_do[k], e_do[k]); end
        total++; if (a_dout[k] !== e_dout[k]) begin bad++; $display("FAIL rnd_dout[%0d] cyc=%0d got=%h want=%h", k, n, a_dout[k], e_dout[k]); end
        total++; if (a_rdy[k] !== e_rdy[k]) begin bad++; $display("FAIL rnd_ready[%0d] cyc=%0d got=%b want=%b", k, n, a_rdy[k], e_rdy[k]); end
        total++; if (a_drop[k] !== e_drop[k]) begin bad++; $display("FAIL rnd_drop[%0d] cyc=%0d got=%b want=%b", k, n, a_drop[k], e_drop[k]); end
        total++; if (a_par[k] !== 1'b0) begin bad++; $display("FAIL rnd_par[%0d] cyc=%0d got=%b want=0", k, n, a_par[k]); end
      end
    end
    clr = 1'b0;
    we  = 1'b0;
  endtask

  initial begin
    #2;
    test_reset();
    test_write_read();
    test_forward();
    test_out_of_range();
    test_clr();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
